// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter (inhibit, framing on device clocks, ack check).
// Latency: every output is registered; pin changes reach the oe outputs after sync + filter + 1 register.
// Backpressure: tx_start is taken only while tx_busy=0; requests while busy are dropped without effect.
//
// Ports:
//   clk, rst_n             system clock, asynchronous active-low reset
//   tx_byte, tx_start      command byte and single-cycle send request
//   tx_busy, rx_inhibit    transfer in progress (rx_inhibit gates the PS/2 receiver)
//   tx_done, tx_error      one-cycle completion pulses (acked / timeout or nack)
//   ps2_clk_in/dat_in      raw open-drain pin levels
//   ps2_clk_oe/dat_oe      1 = pull the line low, 0 = release
//
// Optional build macro PS2_HOST_TX_RETRY_EN: a failed attempt (nack or timeout) restarts
// from the inhibit phase with the latched byte, up to two retries, before tx_error.
module ps2_host_tx #(
    parameter int clock_filter   = 24,
    parameter int inhibit_cycles = 12000,
    parameter int timeout_cycles = 1700000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] tx_byte,
    input  logic       tx_start,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_error,
    output logic       rx_inhibit,
    input  logic       ps2_clk_in,
    input  logic       ps2_dat_in,
    output logic       ps2_clk_oe,
    output logic       ps2_dat_oe
);

    localparam int FLT_W = $clog2(clock_filter + 1);
    localparam int INH_W = $clog2(inhibit_cycles + 1);
    localparam int TMO_W = 21;

    localparam logic [FLT_W-1:0] FLT_LAST = FLT_W'(clock_filter - 1);
    localparam logic [INH_W-1:0] INH_LAST = INH_W'(inhibit_cycles - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(timeout_cycles - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIBIT,
        S_RELEASE,
        S_SEND,
        S_ACK,
        S_WAIT_IDLE
    } state_t;

    // ------------------------------------------------------------------
    // Pin conditioning: 2-FF synchronisers followed by a run-length filter
    // ------------------------------------------------------------------
    logic [1:0]       clk_sync, dat_sync;
    logic [FLT_W-1:0] clk_fcnt, dat_fcnt;
    logic             clk_flt, dat_flt;
    logic             clk_fall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_sync <= 2'b11;
            dat_sync <= 2'b11;
        end else begin
            clk_sync <= {clk_sync[0], ps2_clk_in};
            dat_sync <= {dat_sync[0], ps2_dat_in};
        end
    end

    // clk_fall is asserted in the same cycle clk_flt first reads 0, so the
    // filtered data seen alongside it has passed through an identical pipeline.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_flt  <= 1'b1;
            clk_fcnt <= '0;
            clk_fall <= 1'b0;
        end else begin
            clk_fall <= 1'b0;
            if (clk_sync[1] == clk_flt) begin
                clk_fcnt <= '0;
            end else if (clk_fcnt == FLT_LAST) begin
                clk_flt  <= clk_sync[1];
                clk_fcnt <= '0;
                clk_fall <= clk_flt;
            end else begin
                clk_fcnt <= clk_fcnt + FLT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dat_flt  <= 1'b1;
            dat_fcnt <= '0;
        end else begin
            if (dat_sync[1] == dat_flt) begin
                dat_fcnt <= '0;
            end else if (dat_fcnt == FLT_LAST) begin
                dat_flt  <= dat_sync[1];
                dat_fcnt <= '0;
            end else begin
                dat_fcnt <= dat_fcnt + FLT_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Transmit sequencer
    // ------------------------------------------------------------------
    state_t           state;
    logic [8:0]       frame;      // {odd parity, data byte}
    logic [3:0]       bit_idx;    // falls seen in SEND
    logic [INH_W-1:0] inh_cnt;
    logic [TMO_W-1:0] tmo_cnt;
    logic             ack_ok;
`ifdef PS2_HOST_TX_RETRY_EN
    logic [1:0]       retry_cnt;
`endif

    logic tmo_hit;
    logic attempt_end;
    logic attempt_pass;

    // An attempt ends either on timeout or once the device has released both
    // lines after the ack clock. Timeout is checked first so it beats a
    // coincident fall.
    always_comb begin
        tmo_hit      = 1'b0;
        attempt_end  = 1'b0;
        attempt_pass = 1'b0;
        if ((state == S_SEND) || (state == S_ACK) || (state == S_WAIT_IDLE)) begin
            tmo_hit = (tmo_cnt == TMO_LAST);
        end
        if (tmo_hit) begin
            attempt_end = 1'b1;
        end else if ((state == S_WAIT_IDLE) && clk_flt && dat_flt) begin
            attempt_end  = 1'b1;
            attempt_pass = ack_ok;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            frame      <= '0;
            bit_idx    <= '0;
            inh_cnt    <= '0;
            tmo_cnt    <= '0;
            ack_ok     <= 1'b0;
            tx_busy    <= 1'b0;
            tx_done    <= 1'b0;
            tx_error   <= 1'b0;
            ps2_clk_oe <= 1'b0;
            ps2_dat_oe <= 1'b0;
`ifdef PS2_HOST_TX_RETRY_EN
            retry_cnt  <= '0;
`endif
        end else begin
            tx_done  <= 1'b0;
            tx_error <= 1'b0;

            if ((state == S_SEND) || (state == S_ACK) || (state == S_WAIT_IDLE)) begin
                if (tmo_cnt != {TMO_W{1'b1}}) begin
                    tmo_cnt <= tmo_cnt + TMO_W'(1);
                end
            end

            case (state)
                S_IDLE: begin
                    if (tx_start && !tx_busy) begin
                        frame      <= {~^tx_byte, tx_byte};
                        tx_busy    <= 1'b1;
                        ps2_clk_oe <= 1'b1;
                        inh_cnt    <= '0;
`ifdef PS2_HOST_TX_RETRY_EN
                        retry_cnt  <= '0;
`endif
                        state      <= S_INHIBIT;
                    end
                end
                S_INHIBIT: begin
                    if (inh_cnt == INH_LAST) begin
                        ps2_dat_oe <= 1'b1;    // start bit
                        state      <= S_RELEASE;
                    end else begin
                        inh_cnt <= inh_cnt + INH_W'(1);
                    end
                end
                S_RELEASE: begin
                    ps2_clk_oe <= 1'b0;
                    tmo_cnt    <= '0;
                    bit_idx    <= '0;
                    state      <= S_SEND;
                end
                S_SEND: begin
                    if (clk_fall) begin
                        if (bit_idx == 4'd9) begin
                            ps2_dat_oe <= 1'b0;    // stop bit: line released
                            state      <= S_ACK;
                        end else begin
                            ps2_dat_oe <= ~frame[bit_idx];
                            bit_idx    <= bit_idx + 4'd1;
                        end
                    end
                end
                S_ACK: begin
                    if (clk_fall) begin
                        ack_ok <= ~dat_flt;
                        state  <= S_WAIT_IDLE;
                    end
                end
                S_WAIT_IDLE: begin
                    // completion handled by attempt_end below
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase

            // Attempt completion overrides anything the state case scheduled.
            if (attempt_end) begin
                ps2_clk_oe <= 1'b0;
                ps2_dat_oe <= 1'b0;
                tx_busy    <= 1'b0;
                tx_done    <= attempt_pass;
                tx_error   <= !attempt_pass;
                state      <= S_IDLE;
`ifdef PS2_HOST_TX_RETRY_EN
                if (!attempt_pass && (retry_cnt != 2'd2)) begin
                    retry_cnt  <= retry_cnt + 2'd1;
                    ps2_clk_oe <= 1'b1;
                    tx_busy    <= 1'b1;
                    tx_error   <= 1'b0;
                    inh_cnt    <= '0;
                    state      <= S_INHIBIT;
                end
`endif
            end
        end
    end

    assign rx_inhibit = tx_busy;

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
- Host-to-device PS/2 transmitter: sends one command byte (e.g. 0xED set-LEDs, 0xFF reset) from the system to the keyboard over the same open-drain clock/data pair that ps2com receives on.
- Sits beside ps2com on the `clk` domain (~107.4 MHz system clock).
- Implements the full sequence: clock-inhibit request, data framing on device-generated clocks, and ack check.
- Raises `rx_inhibit` so ps2com ignores the request-to-send frame.

Parameters:
- `clock_filter`, 24: consecutive equal samples needed before a filtered PS/2 line level changes.
- `inhibit_cycles`, 12000: `clk` cycles the host holds PS2 clock low (>100 us).
- `timeout_cycles`, 1700000: maximum `clk` cycles from clock release to ack (~15.8 ms); 21-bit counter.

Ports:
- `clk`  in  1  system clock
- `rst_n`  in  1  asynchronous active-low reset
- `tx_byte`  in  8  byte to send; sampled when `tx_start` is accepted
- `tx_start`  in  1  single-cycle request; accepted only when `tx_busy`=0
- `tx_busy`  out  1  high from accept until `tx_done`/`tx_error`
- `tx_done`  out  1  one-cycle pulse: device acked
- `tx_error`  out  1  one-cycle pulse: timeout or NACK
- `rx_inhibit`  out  1  high while `tx_busy`; gates ps2com
- `ps2_clk_in`  in  1  raw PS2 clock pin level
- `ps2_dat_in`  in  1  raw PS2 data pin level
- `ps2_clk_oe`  out  1  1 = drive PS2 clock low; 0 = release
- `ps2_dat_oe`  out  1  1 = drive PS2 data low; 0 = release

Behaviour:
- Reset: all outputs 0 (both lines released), state IDLE, counters 0. Async assert releases lines immediately, including mid-frame. No `tx_done`/`tx_error` is generated for an aborted frame.
- Input conditioning: 2-FF sync on both pins, then a filter. Filtered level flips after `clock_filter` consecutive opposite samples; reset value is 1. A "fall" is a filtered clock 1->0 transition (one-cycle event).
- IDLE: on `tx_start` && !`tx_busy`:
  - latch `tx_byte`
  - parity = ~^byte (odd)
  - `tx_busy`=1, `ps2_clk_oe`=1, go INHIBIT.
- `tx_start` while busy is ignored with no side effects.
- INHIBIT: count `inhibit_cycles`, then `ps2_dat_oe`=1 (start bit 0). Next cycle `ps2_clk_oe`=0, clear timeout counter, go SEND with bit index 0.
- SEND: on each fall, present the next bit: `ps2_dat_oe` = ~bit.
  - Falls 1-8: data bits, LSB first.
  - Fall 9: parity.
  - Fall 10: stop, data released (`ps2_dat_oe`=0).
  - Then go ACK.
- ACK: on fall 11, sample filtered data.
  - 0: go WAIT_IDLE with result=ok.
  - 1: result=nack, go WAIT_IDLE.
- WAIT_IDLE: wait until filtered clock and data are both 1 (device released). Then:
  - pulse `tx_done` (ok) or `tx_error` (nack)
  - `tx_busy`=0, back to IDLE.
- Timeout: counter runs in SEND/ACK/WAIT_IDLE and saturates. On reaching `timeout_cycles`: release both lines, pulse `tx_error`, `tx_busy`=0, go IDLE.
- A fall occurring in the same cycle as the timeout: the timeout wins.
- `tx_done` and `tx_error` are mutually exclusive and each lasts exactly one cycle.
- `tx_byte` changes after accept have no effect.
- Whole path is one-cycle registered. No combinational path from pins to `oe` outputs.

Optional Feature:
- Macro `PS2_HOST_TX_RETRY_EN`.
- Defined: on NACK or timeout, the frame restarts from INHIBIT with the latched byte, up to 2 retries. `tx_busy` stays high throughout. `tx_error` pulses only after the 3rd failed attempt; `tx_done` pulses on any successful attempt.
- Not defined: the first failure pulses `tx_error` immediately, as described above.

Test Plan:
- 0xED sent to a device model clocking at 12.5 kHz -> `ps2_clk_oe` low for >=12000 cycles; bits observed on device rising edges are start 0, then 1,0,1,1,0,1,1,1, parity 1, stop 1. Device acks -> `tx_done`=1 for 1 cycle, `tx_busy`=0, `oe` outputs 0.
- 0x07 -> parity bit 0. 0x00 -> parity bit 1. Both acked -> `tx_done`.
- Device never clocks -> `tx_error` pulse exactly `timeout_cycles` after clock release, both lines released. With `PS2_HOST_TX_RETRY_EN`: 3 inhibit phases, then one `tx_error`.
- Device leaves data high at the 11th fall -> `tx_error`, no `tx_done`.
- `tx_start` with 0x55 pulsed again mid-frame -> ignored; the first byte (0xED) completes unaltered, only one `tx_done`.
- `rst_n` low after the 4th fall -> `ps2_clk_oe`=`ps2_dat_oe`=0 asynchronously, `tx_busy`=0, no pulses. A subsequent `tx_start` after reset runs a clean frame.
